// File: rtl/pic_mem_dp.sv
// pic_mem_dp: true dual-port picture/sprite memory with two Avalon-MM slave
// ports on one clock, byte-enabled writes, 1-cycle read latency and a
// hardware fill engine that writes one value to every word.
// Optional build macro PIC_MEM_OUTREG_EN adds an output register on both
// read ports (read latency 2).
module pic_mem_dp #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 200,
    parameter int unsigned BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    // s1
    input  logic [ADDR_W-1:0] address,
    input  logic [BE_W-1:0]   byteenable,
    input  logic              chipselect,
    input  logic              write,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic              readdatavalid,
    output logic              waitrequest,
    // s2
    input  logic [ADDR_W-1:0] address2,
    input  logic [BE_W-1:0]   byteenable2,
    input  logic              chipselect2,
    input  logic              write2,
    input  logic [DATA_W-1:0] writedata2,
    output logic [DATA_W-1:0] readdata2,
    output logic              readdatavalid2,
    output logic              waitrequest2,
    // fill engine
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_value,
    output logic              fill_busy
);

    localparam int unsigned LAST = DEPTH - 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    logic [DATA_W-1:0] r_mem [DEPTH];

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [DATA_W-1:0] r_fill_val;
    logic              r_busy;
    logic              w_fill_load;
    logic              w_fill_we;
    logic              w_ptr_last;

    logic              w_inr1, w_inr2;
    logic              w_acc1, w_acc2;
    logic              w_wr1, w_wr2;
    logic              w_rd1, w_rd2;
    logic [DATA_W-1:0] w_rdata1, w_rdata2;

    logic [DATA_W-1:0] r_rdata1, r_rdata2;
    logic              r_rvalid1, r_rvalid2;

    // Host access decode: hosts are stalled whenever the fill engine runs
    assign w_inr1   = ({1'b0, address}  < (ADDR_W + 1)'(DEPTH));
    assign w_inr2   = ({1'b0, address2} < (ADDR_W + 1)'(DEPTH));
    assign w_acc1   = chipselect  & ~r_busy;
    assign w_acc2   = chipselect2 & ~r_busy;
    assign w_wr1    = w_acc1 & write  & w_inr1;
    assign w_wr2    = w_acc2 & write2 & w_inr2;
    assign w_rd1    = w_acc1 & ~write;
    assign w_rd2    = w_acc2 & ~write2;
    assign w_rdata1 = w_inr1 ? r_mem[address]  : '0;
    assign w_rdata2 = w_inr2 ? r_mem[address2] : '0;

    assign w_ptr_last = (r_ptr == ADDR_W'(LAST));

    // Fill FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Fill FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (fill_start) w_state_nxt = S_FILL;
            S_FILL:  if (w_ptr_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Fill FSM outputs: capture on start, write one word per FILL cycle
    always_comb begin
        w_fill_load = 1'b0;
        w_fill_we   = 1'b0;
        case (r_state)
            S_IDLE:  w_fill_load = fill_start;
            S_FILL:  w_fill_we   = 1'b1;
            default: ;
        endcase
    end

    // Fill pointer, captured fill value and registered busy/stall flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr      <= '0;
            r_fill_val <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == S_FILL);
            if (w_fill_load) begin
                r_ptr      <= '0;
                r_fill_val <= fill_value;
            end else if (w_fill_we) begin
                r_ptr <= r_ptr + ADDR_W'(1);
            end
        end
    end

    // Storage array (not reset); s1 lanes are written last so s1 wins collisions
    always_ff @(posedge clk) begin
        if (w_fill_we) begin
            r_mem[r_ptr] <= r_fill_val;
        end else begin
            if (w_wr2) begin
                for (int i = 0; i < int'(BE_W); i++) begin
                    if (byteenable2[i]) r_mem[address2][i*8 +: 8] <= writedata2[i*8 +: 8];
                end
            end
            if (w_wr1) begin
                for (int i = 0; i < int'(BE_W); i++) begin
                    if (byteenable[i]) r_mem[address][i*8 +: 8] <= writedata[i*8 +: 8];
                end
            end
        end
    end

    // First read stage: data held until the next accepted read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata1  <= '0;
            r_rdata2  <= '0;
            r_rvalid1 <= 1'b0;
            r_rvalid2 <= 1'b0;
        end else begin
            r_rvalid1 <= w_rd1;
            r_rvalid2 <= w_rd2;
            if (w_rd1) r_rdata1 <= w_rdata1;
            if (w_rd2) r_rdata2 <= w_rdata2;
        end
    end

`ifdef PIC_MEM_OUTREG_EN
    logic [DATA_W-1:0] r_rdata1_q, r_rdata2_q;
    logic              r_rvalid1_q, r_rvalid2_q;

    // Optional output register stage on both ports
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata1_q  <= '0;
            r_rdata2_q  <= '0;
            r_rvalid1_q <= 1'b0;
            r_rvalid2_q <= 1'b0;
        end else begin
            r_rvalid1_q <= r_rvalid1;
            r_rvalid2_q <= r_rvalid2;
            if (r_rvalid1) r_rdata1_q <= r_rdata1;
            if (r_rvalid2) r_rdata2_q <= r_rdata2;
        end
    end

    assign readdata       = r_rdata1_q;
    assign readdatavalid  = r_rvalid1_q;
    assign readdata2      = r_rdata2_q;
    assign readdatavalid2 = r_rvalid2_q;
`else
    assign readdata       = r_rdata1;
    assign readdatavalid  = r_rvalid1;
    assign readdata2      = r_rdata2;
    assign readdatavalid2 = r_rvalid2;
`endif

    assign waitrequest  = r_busy;
    assign waitrequest2 = r_busy;
    assign fill_busy    = r_busy;

endmodule

// File: tb/tb_pic_mem_dp.sv
// Self-checking bench for pic_mem_dp (default parameters) with a word-array
// reference model and timestamped expected-read queues.
module tb_pic_mem_dp;

    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 200;
`ifdef PIC_MEM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        int          due;
        logic [15:0] val;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] address = '0, address2 = '0;
    logic [1:0]    byteenable = '0, byteenable2 = '0;
    logic          chipselect = 1'b0, chipselect2 = 1'b0;
    logic          write = 1'b0, write2 = 1'b0;
    logic [DW-1:0] writedata = '0, writedata2 = '0;
    logic [DW-1:0] readdata, readdata2;
    logic          readdatavalid, readdatavalid2;
    logic          waitrequest, waitrequest2;
    logic          fill_start = 1'b0;
    logic [DW-1:0] fill_value = '0;
    logic          fill_busy;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;
    logic [15:0] model [0:255];

    pic_mem_dp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .address(address), .byteenable(byteenable), .chipselect(chipselect),
        .write(write), .writedata(writedata), .readdata(readdata),
        .readdatavalid(readdatavalid), .waitrequest(waitrequest),
        .address2(address2), .byteenable2(byteenable2), .chipselect2(chipselect2),
        .write2(write2), .writedata2(writedata2), .readdata2(readdata2),
        .readdatavalid2(readdatavalid2), .waitrequest2(waitrequest2),
        .fill_start(fill_start), .fill_value(fill_value), .fill_busy(fill_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                          input logic [1:0] be);
        logic [15:0] r;
        r = old;
        if (be[0]) r[7:0]  = nw[7:0];
        if (be[1]) r[15:8] = nw[15:8];
        return r;
    endfunction

    function automatic logic [15:0] mexp(input int a);
        return (a < DEPTH) ? model[a] : 16'h0000;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_ports();
        chipselect = 1'b0; write = 1'b0;
        chipselect2 = 1'b0; write2 = 1'b0;
    endtask

    task automatic host_write(input int p, input int a, input logic [15:0] d, input logic [1:0] be);
        if (p == 1) begin
            chipselect = 1'b1; write = 1'b1; address = AW'(a); writedata = d; byteenable = be;
        end else begin
            chipselect2 = 1'b1; write2 = 1'b1; address2 = AW'(a); writedata2 = d; byteenable2 = be;
        end
        cycle();
        idle_ports();
        if (a < DEPTH) model[a] = merge(model[a], d, be);
    endtask

    // Waits (bounded) for readdatavalid on port p; lat = cycles after acceptance, 0 if none
    task automatic wait_valid(input int p, output logic [15:0] d, output int lat);
        lat = 0;
        d   = 'x;
        for (int k = 1; k <= LAT + 3; k++) begin
            if ((p == 1 && readdatavalid === 1'b1) || (p == 2 && readdatavalid2 === 1'b1)) begin
                lat = k;
                d   = (p == 1) ? readdata : readdata2;
                break;
            end
            cycle();
        end
    endtask

    task automatic host_read(input int p, input int a, output logic [15:0] d, output int lat);
        if (p == 1) begin
            chipselect = 1'b1; write = 1'b0; address = AW'(a);
        end else begin
            chipselect2 = 1'b1; write2 = 1'b0; address2 = AW'(a);
        end
        cycle();
        idle_ports();
        wait_valid(p, d, lat);
    endtask

    task automatic test_reset();
        cycle();
        vecs++;
        if (readdata !== 16'h0 || readdata2 !== 16'h0)
            begin errs++; $display("FAIL reset_readdata: got %h/%h want 0000/0000", readdata, readdata2); end
        vecs++;
        if (readdatavalid !== 1'b0 || readdatavalid2 !== 1'b0)
            begin errs++; $display("FAIL reset_valid: got %b/%b want 0/0", readdatavalid, readdatavalid2); end
        vecs++;
        if (waitrequest !== 1'b0 || waitrequest2 !== 1'b0 || fill_busy !== 1'b0)
            begin errs++; $display("FAIL reset_wait_busy: got %b%b%b want 000", waitrequest, waitrequest2, fill_busy); end
        #2 reset = 1'b0;
        cycle();
    endtask

    task automatic test_fill();
        int busy_cnt;
        logic saw_v;
        logic [15:0] d;
        int lat;
        fill_value = 16'h07E0;
        fill_start = 1'b1;
        cycle();
        fill_start = 1'b0;
        vecs++;
        if (fill_busy !== 1'b1 || waitrequest !== 1'b1 || waitrequest2 !== 1'b1)
            begin errs++; $display("FAIL fill_rise: busy/wr/wr2 %b%b%b want 111", fill_busy, waitrequest, waitrequest2); end
        chipselect = 1'b1; write = 1'b0; address = AW'(100);
        busy_cnt = 0;
        saw_v = 1'b0;
        while (fill_busy === 1'b1 && busy_cnt < 1000) begin
            if (readdatavalid === 1'b1) saw_v = 1'b1;
            busy_cnt++;
            cycle();
        end
        vecs++;
        if (busy_cnt != DEPTH)
            begin errs++; $display("FAIL fill_busy_len: got %0d cycles want %0d", busy_cnt, DEPTH); end
        vecs++;
        if (saw_v !== 1'b0 || waitrequest !== 1'b0)
            begin errs++; $display("FAIL fill_stall: valid_during_fill=%b waitrequest=%b want 0/0", saw_v, waitrequest); end
        cycle();
        idle_ports();
        wait_valid(1, d, lat);
        vecs++;
        if (lat != LAT || d !== 16'h07E0)
            begin errs++; $display("FAIL fill_stalled_read: got %h lat %0d want 07e0 lat %0d", d, lat, LAT); end
        for (int a = 0; a < DEPTH; a++) model[a] = 16'h07E0;
        host_read(2, 0, d, lat);
        vecs++;
        if (lat != LAT || d !== 16'h07E0)
            begin errs++; $display("FAIL fill_addr0: got %h lat %0d want 07e0", d, lat); end
        host_read(2, DEPTH - 1, d, lat);
        vecs++;
        if (lat != LAT || d !== 16'h07E0)
            begin errs++; $display("FAIL fill_addr199: got %h lat %0d want 07e0", d, lat); end
    endtask

    task automatic test_byte_enable();
        logic [15:0] d;
        int lat;
        host_write(1, 5, 16'hABCD, 2'b11);
        host_write(1, 5, 16'h1200, 2'b10);
        host_read(2, 5, d, lat);
        vecs++;
        if (lat != LAT || d !== 16'h12CD)
            begin errs++; $display("FAIL byte_enable: got %h lat %0d want 12cd lat %0d", d, lat, LAT); end
        cycle();
        vecs++;
        if (readdatavalid2 !== 1'b0 || readdata2 !== 16'h12CD)
            begin errs++; $display("FAIL valid_pulse: valid2=%b data2=%h want 0/12cd", readdatavalid2, readdata2); end
    endtask

    task automatic test_collision();
        logic [15:0] d;
        int lat;
        host_write(1, 9, 16'h0000, 2'b11);
        // s1 reads 9 while s2 writes it in the same cycle: old data expected
        chipselect = 1'b1; write = 1'b0; address = AW'(9);
        chipselect2 = 1'b1; write2 = 1'b1; address2 = AW'(9); writedata2 = 16'h3333; byteenable2 = 2'b01;
        cycle();
        idle_ports();
        model[9] = merge(model[9], 16'h3333, 2'b01);
        wait_valid(1, d, lat);
        vecs++;
        if (lat != LAT || d !== 16'h0000)
            begin errs++; $display("FAIL read_before_write: got %h lat %0d want 0000", d, lat); end
        // both ports write 9 in one cycle
        chipselect = 1'b1; write = 1'b1; address = AW'(9); writedata = 16'h1111; byteenable = 2'b01;
        chipselect2 = 1'b1; write2 = 1'b1; address2 = AW'(9); writedata2 = 16'h2222; byteenable2 = 2'b11;
        cycle();
        idle_ports();
        model[9] = 16'h2211;
        host_read(1, 9, d, lat);
        vecs++;
        if (lat != LAT || d !== 16'h2211)
            begin errs++; $display("FAIL collision: got %h lat %0d want 2211", d, lat); end
    endtask

    task automatic test_out_of_range();
        logic [15:0] d;
        int lat;
        host_write(1, 199, 16'h5A5A, 2'b11);
        host_write(1, 200, 16'hFFFF, 2'b11);
        host_read(1, 199, d, lat);
        vecs++;
        if (lat != LAT || d !== 16'h5A5A)
            begin errs++; $display("FAIL oor_199: got %h lat %0d want 5a5a", d, lat); end
        host_read(1, 200, d, lat);
        vecs++;
        if (lat != LAT || d !== 16'h0000)
            begin errs++; $display("FAIL oor_200: got %h lat %0d want 0000 lat %0d", d, lat, LAT); end
        host_read(2, 255, d, lat);
        vecs++;
        if (lat != LAT || d !== 16'h0000)
            begin errs++; $display("FAIL oor_255: got %h lat %0d want 0000", d, lat); end
    endtask

    task automatic test_random();
        exp_t q1[$];
        exp_t q2[$];
        exp_t e;
        int n = 300;
        for (int it = 0; it < n + LAT + 1; it++) begin
            if (it < n) begin
                chipselect  = ($urandom_range(0, 3) != 0);
                write       = 1'($urandom_range(0, 1));
                address     = AW'($urandom_range(0, 209));
                byteenable  = 2'($urandom_range(0, 3));
                writedata   = 16'($urandom);
                chipselect2 = ($urandom_range(0, 3) != 0);
                write2      = 1'($urandom_range(0, 1));
                address2    = AW'($urandom_range(0, 209));
                byteenable2 = 2'($urandom_range(0, 3));
                writedata2  = 16'($urandom);
                if (chipselect && !write) begin e.due = cyc + LAT; e.val = mexp(int'(address)); q1.push_back(e); end
                if (chipselect2 && !write2) begin e.due = cyc + LAT; e.val = mexp(int'(address2)); q2.push_back(e); end
                if (chipselect2 && write2 && address2 < DEPTH)
                    model[address2] = merge(model[address2], writedata2, byteenable2);
                if (chipselect && write && address < DEPTH)
                    model[address] = merge(model[address], writedata, byteenable);
            end else begin
                idle_ports();
            end
            cycle();
            vecs++;
            if (q1.size() > 0 && q1[0].due == cyc) begin
                if (readdatavalid !== 1'b1 || readdata !== q1[0].val)
                    begin errs++; $display("FAIL rand_s1 cyc %0d: valid %b data %h want 1 %h", cyc, readdatavalid, readdata, q1[0].val); end
                void'(q1.pop_front());
            end else if (readdatavalid !== 1'b0) begin
                errs++; $display("FAIL rand_s1_spurious cyc %0d: valid %b want 0", cyc, readdatavalid);
            end
            vecs++;
            if (q2.size() > 0 && q2[0].due == cyc) begin
                if (readdatavalid2 !== 1'b1 || readdata2 !== q2[0].val)
                    begin errs++; $display("FAIL rand_s2 cyc %0d: valid %b data %h want 1 %h", cyc, readdatavalid2, readdata2, q2[0].val); end
                void'(q2.pop_front());
            end else if (readdatavalid2 !== 1'b0) begin
                errs++; $display("FAIL rand_s2_spurious cyc %0d: valid %b want 0", cyc, readdatavalid2);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t q[$];
        exp_t e;
        // s1 reads consecutive words every cycle while s2 overwrites each one in the same cycle
        for (int it = 0; it < 16 + LAT + 1; it++) begin
            idle_ports();
            if (it < 8) begin
                chipselect = 1'b1; write = 1'b0; address = AW'(20 + it);
                chipselect2 = 1'b1; write2 = 1'b1; address2 = AW'(20 + it);
                writedata2 = 16'(16'hA000 + it * 3); byteenable2 = 2'b11;
                e.due = cyc + LAT; e.val = model[20 + it]; q.push_back(e);
                model[20 + it] = writedata2;
            end else if (it < 16) begin
                chipselect = 1'b1; write = 1'b0; address = AW'(it + 12);
                e.due = cyc + LAT; e.val = model[it + 12]; q.push_back(e);
            end
            cycle();
            vecs++;
            if (q.size() > 0 && q[0].due == cyc) begin
                if (readdatavalid !== 1'b1 || readdata !== q[0].val)
                    begin errs++; $display("FAIL b2b cyc %0d: valid %b data %h want 1 %h", cyc, readdatavalid, readdata, q[0].val); end
                void'(q.pop_front());
            end else if (readdatavalid !== 1'b0) begin
                errs++; $display("FAIL b2b_spurious cyc %0d: valid %b want 0", cyc, readdatavalid);
            end
        end
    endtask

    task automatic test_fill_with_access();
        logic [15:0] d;
        int lat;
        int guard;
        host_write(1, 7, 16'hC0DE, 2'b11);
        fill_value = 16'h5A5A;
        fill_start = 1'b1;
        chipselect = 1'b1; write = 1'b0; address = AW'(7);
        cycle();
        fill_start = 1'b0;
        idle_ports();
        wait_valid(1, d, lat);
        vecs++;
        if (lat != LAT || d !== 16'hC0DE || fill_busy !== 1'b1)
            begin errs++; $display("FAIL fill_with_access: data %h lat %0d busy %b want c0de lat %0d busy 1", d, lat, fill_busy, LAT); end
        guard = 0;
        while (fill_busy === 1'b1 && guard < 1000) begin guard++; cycle(); end
        for (int a = 0; a < DEPTH; a++) model[a] = 16'h5A5A;
        host_read(1, 7, d, lat);
        vecs++;
        if (lat != LAT || d !== 16'h5A5A)
            begin errs++; $display("FAIL fill_after_access: got %h lat %0d want 5a5a", d, lat); end
    endtask

    task automatic test_reset_mid_fill();
        logic [15:0] d;
        int lat;
        int busy_cnt;
        host_write(1, 150, 16'hBEEF, 2'b11);
        host_write(2, 10, 16'h1111, 2'b11);
        fill_value = 16'h07E0;
        fill_start = 1'b1;
        cycle();
        fill_start = 1'b0;
        repeat (50) cycle();
        // fill has written words 0..49 so far
        reset = 1'b1;
        #1;
        vecs++;
        if (fill_busy !== 1'b0 || waitrequest !== 1'b0 || waitrequest2 !== 1'b0)
            begin errs++; $display("FAIL reset_async: busy/wr/wr2 %b%b%b want 000", fill_busy, waitrequest, waitrequest2); end
        for (int a = 0; a < 50; a++) model[a] = 16'h07E0;
        @(posedge clk);
        #3 reset = 1'b0;
        cycle();
        host_read(1, 10, d, lat);
        vecs++;
        if (lat != LAT || d !== 16'h07E0)
            begin errs++; $display("FAIL mid_fill_addr10: got %h lat %0d want 07e0", d, lat); end
        host_read(2, 150, d, lat);
        vecs++;
        if (lat != LAT || d !== model[150])
            begin errs++; $display("FAIL mid_fill_addr150: got %h lat %0d want %h", d, lat, model[150]); end
        fill_value = 16'hF81F;
        fill_start = 1'b1;
        cycle();
        fill_start = 1'b0;
        busy_cnt = 0;
        while (fill_busy === 1'b1 && busy_cnt < 1000) begin busy_cnt++; cycle(); end
        vecs++;
        if (busy_cnt != DEPTH)
            begin errs++; $display("FAIL refill_len: got %0d cycles want %0d", busy_cnt, DEPTH); end
        for (int a = 0; a < DEPTH; a++) model[a] = 16'hF81F;
        host_read(1, 150, d, lat);
        vecs++;
        if (lat != LAT || d !== 16'hF81F)
            begin errs++; $display("FAIL refill_addr150: got %h lat %0d want f81f", d, lat); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_byte_enable();
        test_collision();
        test_out_of_range();
        test_random();
        test_back_to_back();
        test_fill_with_access();
        test_reset_mid_fill();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
